// File: rtl/pix_src_sched.sv
// Pixel source scheduler: selects camera or SPI frames at frame boundaries,
// assembles SPI byte pairs into pixels and issues registered pixel/X/Y/status strobes.
module pix_src_sched #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 16,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H)
) (
    input  logic             clk_p,
    input  logic             rst,
    input  logic             src_sel,
    input  logic             cam_dv,
    input  logic             cam_sof,
    input  logic [PIX_W-1:0] cam_pix,
    input  logic             spi_byte_vld,
    input  logic [7:0]       spi_byte,
    input  logic             spi_strm_en,
    input  logic             spi_sof,
    output logic             pix_en,
    output logic             pix_sof,
    output logic [PIX_W-1:0] pix_data,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             active_src,
    output logic             busy,
    output logic             frame_done,
    output logic             short_frame,
    output logic [15:0]      drop_cnt
);

    typedef enum logic [1:0] {IDLE, RUN_CAM, RUN_SPI} state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [XW-1:0]      x_q, x_d, xc;
    logic [YW-1:0]      y_q, y_d, yc;
    logic               last_q, last_d;
    logic               pix_en_d, pix_sof_d, active_src_d, busy_d, short_frame_d;
    logic [PIX_W-1:0]   pix_data_d;
    logic [XW-1:0]      pix_x_d;
    logic [YW-1:0]      pix_y_d;
    logic [15:0]        drop_cnt_d;
    logic [16:0]        drop_sum;
    logic [1:0]         drop_inc;
    logic               spi_pix_vld_c, idle_c, sel_c, sof_c, vld_c, oth_c;
    logic [PIX_W-1:0]   spi_pix_c, dat_c;

    // SPI byte pairing; a disabled stream or sof restarts at the high byte
    always_comb begin
        phase_d       = phase_q;
        hi_d          = hi_q;
        spi_pix_vld_c = 1'b0;
        spi_pix_c     = PIX_W'({hi_q, spi_byte});
        if (!spi_strm_en) begin
            phase_d = 1'b1;
        end else if (spi_sof) begin
            phase_d = 1'b1;
            if (spi_byte_vld) begin
                hi_d    = spi_byte;
                phase_d = 1'b0;
            end
        end else if (spi_byte_vld) begin
            if (phase_q) begin
                hi_d    = spi_byte;
                phase_d = 1'b0;
            end else begin
                phase_d       = 1'b1;
                spi_pix_vld_c = 1'b1;
            end
        end
    end

    // Frame scheduling; sof is applied before a coincident pixel
    always_comb begin
        idle_c        = (state_q == IDLE);
        sel_c         = idle_c ? src_sel : active_src;
        sof_c         = sel_c ? spi_sof : cam_sof;
        vld_c         = sel_c ? spi_pix_vld_c : cam_dv;
        dat_c         = sel_c ? spi_pix_c : cam_pix;
        oth_c         = sel_c ? cam_dv : spi_pix_vld_c;

        state_d       = state_q;
        active_src_d  = idle_c ? src_sel : active_src;
        pix_en_d      = 1'b0;
        pix_sof_d     = 1'b0;
        pix_data_d    = pix_data;
        pix_x_d       = pix_x;
        pix_y_d       = pix_y;
        short_frame_d = 1'b0;
        last_d        = 1'b0;
        drop_inc      = 2'd0;
        xc            = x_q;
        yc            = y_q;

        if (sof_c) begin
            xc = '0;
            yc = '0;
            if (idle_c) begin
                state_d = src_sel ? RUN_SPI : RUN_CAM;
            end else if ((x_q != '0) || (y_q != '0)) begin
                short_frame_d = 1'b1;
            end
        end
        x_d = xc;
        y_d = yc;

        if (vld_c) begin
            if (state_d != IDLE) begin
                pix_en_d   = 1'b1;
                pix_sof_d  = (xc == '0) && (yc == '0);
                pix_data_d = dat_c;
                pix_x_d    = xc;
                pix_y_d    = yc;
                if (xc == XW'(IMG_W - 1)) begin
                    x_d = '0;
                    if (yc == YW'(IMG_H - 1)) begin
                        y_d     = '0;
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end else begin
                        y_d = yc + YW'(1);
                    end
                end else begin
                    x_d = xc + XW'(1);
                end
            end else begin
                drop_inc = drop_inc + 2'd1;
            end
        end
        if (oth_c) begin
            drop_inc = drop_inc + 2'd1;
        end

        drop_sum   = {1'b0, drop_cnt} + 17'(drop_inc);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b1;
            hi_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            last_q      <= 1'b0;
            pix_en      <= 1'b0;
            pix_sof     <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            active_src  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            last_q      <= last_d;
            pix_en      <= pix_en_d;
            pix_sof     <= pix_sof_d;
            pix_data    <= pix_data_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            active_src  <= active_src_d;
            busy        <= busy_d;
            frame_done  <= last_q;
            short_frame <= short_frame_d;
            drop_cnt    <= drop_cnt_d;
        end
    end

endmodule
